// File: rtl/apu_pkg.sv
// Shared APU constants: channel count, note-index and ROM word widths, and the
// derived ROM address width used by the sequencers, the ROM and its arbiter.
package apu_pkg;

    localparam int APU_NUM_CH    = 4;
    localparam int APU_CH_ADDR_W = 5;
    localparam int APU_DATA_W    = 16;

    // Keeps index vectors at least one bit wide when only one channel exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int APU_CH_IDX_W   = idx_width(APU_NUM_CH);
    localparam int APU_ROM_ADDR_W = APU_CH_IDX_W + APU_CH_ADDR_W;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
// Holds no state; the pointer lives in the caller.
module rr_arbiter
    import apu_pkg::*;
#(
    parameter int NUM_CH = APU_NUM_CH,
    parameter int IDX_W  = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_win,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    localparam logic [IDX_W:0]    NUM_CH_W = (IDX_W + 1)'(NUM_CH);
    localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH - 1){1'b0}}, 1'b1};

    logic [IDX_W:0]   cand_w_s;
    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Walk channels from the pointer upward with wrap; o_any doubles as "already won".
    always_comb begin
        o_win    = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        cand_w_s = '0;
        cand_s   = '0;
        hit_s    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand_w_s = {1'b0, i_ptr} + (IDX_W + 1)'(i);
            cand_s   = (cand_w_s >= NUM_CH_W) ? IDX_W'(cand_w_s - NUM_CH_W)
                                              : cand_w_s[IDX_W-1:0];
            hit_s    = ~o_any & i_req[cand_s];
            o_win    = o_win | (hit_s ? (ONE_HOT0 << cand_s) : '0);
            o_idx    = hit_s ? cand_s : o_idx;
            o_any    = o_any | i_req[cand_s];
        end
    end

endmodule

// File: rtl/note_rom_arbiter.sv
// Shares one synchronous note ROM between channel sequencers: round-robin grant,
// registered {channel, index} address, and a per-channel return strobe two cycles later.
module note_rom_arbiter
    import apu_pkg::*;
#(
    parameter int NUM_CH    = APU_NUM_CH,
    parameter int CH_ADDR_W = APU_CH_ADDR_W,
    parameter int DATA_W    = APU_DATA_W
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic [NUM_CH-1:0]                       i_req,
    input  logic [NUM_CH*CH_ADDR_W-1:0]             i_addr,
    output logic [NUM_CH-1:0]                       o_gnt,
    output logic [idx_width(NUM_CH)+CH_ADDR_W-1:0]  o_rom_addr,
    input  logic [DATA_W-1:0]                       i_rom_data,
    output logic [DATA_W-1:0]                       o_rdata,
    output logic [NUM_CH-1:0]                       o_rdata_valid
);

    localparam int               IDX_W      = idx_width(NUM_CH);
    localparam int               ROM_ADDR_W = IDX_W + CH_ADDR_W;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CH - 1);

    logic [NUM_CH-1:0]     gnt_q,      gnt_d;
    logic [IDX_W-1:0]      ptr_q,      ptr_d;
    logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [NUM_CH-1:0]     valid_q,    valid_d;
    logic [DATA_W-1:0]     rdata_q,    rdata_d;

    logic [NUM_CH-1:0]     elig_s;
    logic [NUM_CH-1:0]     win_s;
    logic [IDX_W-1:0]      win_idx_s;
    logic                  win_any_s;

    // The channel shown o_gnt this cycle still has i_req up, so it must sit out.
    assign elig_s = i_req & ~gnt_q;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr (
        .i_req  (elig_s),
        .i_ptr  (ptr_q),
        .o_win  (win_s),
        .o_idx  (win_idx_s),
        .o_any  (win_any_s)
    );

    // Next-state: grant/address stage, return-strobe stage and held read data.
    always_comb begin
        gnt_d      = win_s;
        valid_d    = gnt_q;
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        rdata_d    = rdata_q;
        if (win_any_s) begin
            ptr_d      = (win_idx_s == LAST_IDX) ? '0 : win_idx_s + 1'b1;
            rom_addr_d = {win_idx_s, i_addr[win_idx_s*CH_ADDR_W +: CH_ADDR_W]};
        end else begin
            ptr_d      = ptr_q;
            rom_addr_d = rom_addr_q;
        end
        // ROM word arrives in the strobe cycle itself, so it is passed straight through.
        if (|valid_q) begin
            rdata_d = i_rom_data;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers; reset also kills any read still in the pipe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gnt_q      <= '0;
            ptr_q      <= '0;
            rom_addr_q <= '0;
            valid_q    <= '0;
            rdata_q    <= '0;
        end else begin
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
            valid_q    <= valid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign o_gnt         = gnt_q;
    assign o_rom_addr    = rom_addr_q;
    assign o_rdata_valid = valid_q;
    assign o_rdata       = rdata_d;

endmodule

// File: tb/tb_note_rom_arbiter.sv
// Bench for note_rom_arbiter: directed scenarios plus randomized requesters,
// all checked against a per-cycle channel-index reference model.
module tb_note_rom_arbiter;
    import apu_pkg::*;

    localparam int N   = APU_NUM_CH;
    localparam int AW  = APU_CH_ADDR_W;
    localparam int DW  = APU_DATA_W;
    localparam int RAW = APU_ROM_ADDR_W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N-1:0]    gnt;
    logic [RAW-1:0]  rom_addr;
    logic [DW-1:0]   rom_data = '0;
    logic [DW-1:0]   rdata;
    logic [N-1:0]    rvalid;

    int total = 0;
    int bad   = 0;

    // Reference model state: channel numbers (-1 = none), not bit vectors.
    int m_p = 0, m_g = -1, m_v = -1, m_addr = 0, m_rdata = 0;

    always #5 clk = ~clk;

    note_rom_arbiter dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_addr        (addr),
        .o_gnt         (gnt),
        .o_rom_addr    (rom_addr),
        .i_rom_data    (rom_data),
        .o_rdata       (rdata),
        .o_rdata_valid (rvalid)
    );

    // Synchronous ROM model: data = 0xA000 | address, one cycle latency.
    always @(posedge clk) rom_data <= 16'hA000 | DW'(rom_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ch_addr(input int k);
        return int'(addr[k*AW +: AW]);
    endfunction

    function automatic logic [31:0] bit_of(input int ch);
        return (ch < 0) ? 32'd0 : (32'd1 << ch);
    endfunction

    // Advance one clock: predict from the inputs being sampled, then compare.
    task automatic tick();
        int win;
        int n_p, n_g, n_v, n_addr, n_rdata;
        if (rst) begin
            n_p = 0; n_g = -1; n_v = -1; n_addr = 0; n_rdata = 0;
        end else begin
            win = -1;
            for (int off = 0; off < N; off++) begin
                int c;
                c = (m_p + off) % N;
                if (win < 0 && req[c] && c != m_g) win = c;
            end
            n_v     = m_g;
            n_rdata = (m_g >= 0) ? (32'hA000 | m_addr) : m_rdata;
            if (win >= 0) begin
                n_g    = win;
                n_addr = win * (1 << AW) + ch_addr(win);
                n_p    = (win + 1) % N;
            end else begin
                n_g    = -1;
                n_addr = m_addr;
                n_p    = m_p;
            end
        end
        @(posedge clk);
        #1;
        m_p = n_p; m_g = n_g; m_v = n_v; m_addr = n_addr; m_rdata = n_rdata;
        check_eq("gnt", 32'(gnt), bit_of(m_g));
        check_eq("rom_addr", 32'(rom_addr), m_addr);
        check_eq("rvalid", 32'(rvalid), bit_of(m_v));
        check_eq("rdata", 32'(rdata), m_rdata);
    endtask

    initial begin
        int r;

        // Reset state
        rst = 1'b1; req = '0; addr = '0;
        tick(); tick();
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_rdata", 32'(rdata), 32'd0);

        // Single request, channel 0, index 5
        rst = 1'b0; req = 4'b0001; addr[0 +: AW] = 5'd5;
        tick();
        check_eq("single_gnt", 32'(gnt), 32'h1);
        check_eq("single_addr", 32'(rom_addr), 32'h05);
        req = 4'b0000;
        tick();
        check_eq("single_valid", 32'(rvalid), 32'h1);
        check_eq("single_data", 32'(rdata), 32'hA005);
        tick();
        check_eq("hold_data", 32'(rdata), 32'hA005);
        check_eq("hold_addr", 32'(rom_addr), 32'h05);

        // All channels request, each drops after its grant
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < N; k++) addr[k*AW +: AW] = AW'(k + 1);
        for (int i = 0; i < N; i++) begin
            tick();
            check_eq("all_gnt", 32'(gnt), 32'd1 << i);
            check_eq("all_addr", 32'(rom_addr), 32'(i * 32 + i + 1));
            if (i > 0) check_eq("all_valid", 32'(rvalid), 32'd1 << (i - 1));
            req[i] = 1'b0;
        end
        tick();
        check_eq("all_valid_last", 32'(rvalid), 32'h8);
        check_eq("all_data_last", 32'(rdata), 32'hA000 | 32'(3 * 32 + 4));

        // Reset asserted in the cycle channel 2 is granted
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        tick(); req[0] = 1'b0;
        tick(); req[1] = 1'b0;
        tick();
        check_eq("mid_gnt", 32'(gnt), 32'h4);
        rst = 1'b1;
        tick();
        check_eq("mid_valid", 32'(rvalid), 32'd0);
        rst = 1'b0; req = 4'b1111;
        tick();
        check_eq("mid_post_gnt", 32'(gnt), 32'h1);
        check_eq("mid_post_valid", 32'(rvalid), 32'd0);

        // Randomized requesters obeying the request protocol
        req = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (req[k] && m_g == k) begin
                    if ($urandom_range(0, 1) == 0) req[k] = 1'b0;
                    else addr[k*AW +: AW] = AW'($urandom);
                end else if (req[k]) begin
                    r = $urandom_range(0, 15);
                    if (r == 0) req[k] = 1'b0;
                    else if (r == 1) addr[k*AW +: AW] = AW'($urandom);
                end else if ($urandom_range(0, 2) == 0) begin
                    req[k] = 1'b1;
                    addr[k*AW +: AW] = AW'($urandom);
                end
            end
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_rom_arbiter.md
NOTE_ROM_ARBITER -- requirements
Module: note_rom_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of channel sequencers sharing the note ROM.
REQ-002 The block SHALL have parameter CH_ADDR_W, default 5: per-channel note-index width.
REQ-003 The block SHALL have parameter DATA_W, default 16: ROM word width.
REQ-004 The block SHALL have port i_clk, input, 1: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-006 The block SHALL have port i_req, input, NUM_CH: per-channel read request, level, held until granted.
REQ-007 The block SHALL have port i_addr, input, NUM_CH*CH_ADDR_W: per-channel note index; channel k occupies bits [k*CH_ADDR_W +: CH_ADDR_W].
REQ-008 The block SHALL have port o_gnt, output, NUM_CH: one-hot grant pulse, one cycle.
REQ-009 The block SHALL have port o_rom_addr, output, clog2(NUM_CH)+CH_ADDR_W: registered ROM address, {channel, note index}.
REQ-010 The block SHALL have port i_rom_data, input, DATA_W: synchronous ROM output, valid one cycle after o_rom_addr.
REQ-011 The block SHALL have port o_rdata, output, DATA_W: returned ROM word.
REQ-012 The block SHALL have port o_rdata_valid, output, NUM_CH: one-hot per-channel return strobe, one cycle.

Function
REQ-013 Arbitration SHALL run every cycle over eligible channels, i.e. i_req high and not granted in the current cycle.
REQ-014 Priority SHALL be round-robin: search starts at pointer p; after granting channel k, p SHALL become (k+1) mod NUM_CH.
REQ-015 With no eligible channel, p SHALL hold and o_gnt SHALL be all-zero next cycle.
REQ-016 A winner k arbitrated in cycle N SHALL produce o_gnt[k]=1 and o_rom_addr={k, i_addr[k] as sampled in N} in cycle N+1.
REQ-017 In cycle N+2, o_rdata SHALL equal i_rom_data and o_rdata_valid[k] SHALL be 1; total request-to-data latency is 2 cycles.
REQ-018 o_rdata SHALL hold its last value when o_rdata_valid is zero.
REQ-019 o_rom_addr SHALL hold its last value when no grant is issued.
REQ-020 At most one o_gnt bit and one o_rdata_valid bit SHALL be high in any cycle; sustained throughput is one read per cycle.
REQ-021 The channel granted in cycle N+1 SHALL be masked from arbitration in N+1, because its i_req is still high. A requester SHALL drop i_req in the cycle after seeing o_gnt, or re-assert it for a new read.
REQ-022 A requester SHALL keep i_addr stable while i_req is high. Changes during an ungranted request are sampled at arbitration.
REQ-023 A requester dropping i_req before grant SHALL simply be skipped; no grant or valid is issued for it.
REQ-024 Pointer wrap: after granting channel NUM_CH-1, p SHALL become 0.
REQ-025 Starvation bound: a continuously requesting channel SHALL be granted within NUM_CH cycles.

Reset
REQ-026 On i_rst, o_gnt SHALL be 0, o_rdata_valid SHALL be 0, o_rom_addr SHALL be 0, o_rdata SHALL be 0, and p SHALL be 0 on the next edge.
REQ-027 Reset mid-operation SHALL discard any in-flight read: no o_rdata_valid SHALL follow a grant or address issued before or during reset.
REQ-028 The first arbitration after reset deassertion SHALL start from channel 0.

Structure
REQ-029 NUM_CH, CH_ADDR_W, DATA_W defaults and the derived ROM address width SHALL live in shared package apu_pkg, used by note_sequencer and the ROM.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request mask and pointer; outputs: one-hot winner, index, any-valid). It SHALL be purely combinational; pointer and pipeline registers stay in note_rom_arbiter.

Verification (ROM model: data = 0xA000 | rom_addr, 1-cycle latency)
REQ-031 Single request: reset, then i_req=0001, addr0=5 at N -> o_gnt=0001 and o_rom_addr=0x05 at N+1; o_rdata_valid=0001 and o_rdata=0xA005 at N+2.
REQ-032 All request: i_req=1111 held, each channel dropping i_req after its grant -> grants 0001, 0010, 0100, 1000 on consecutive cycles; addresses {ch,idx} correct; four valids in the same order.
REQ-033 Fairness and wrap: ch3 and ch0 request continuously, re-requesting immediately -> grants alternate 1000/0001 after the first; each is granted at most every 2 cycles; p wraps 3->0.
REQ-034 Same-channel mask: ch2 holds i_req one extra cycle after its grant -> exactly one grant in the grant cycle, no double grant in the cycle the mask covers; a second grant to ch2 only if i_req remains high afterwards.
REQ-035 Reset mid-flight: assert i_rst in the cycle o_gnt=0100 -> no o_rdata_valid in the following cycles; the first post-reset grant with i_req=1111 is 0001.
REQ-036 Withdrawn request: ch1 raises i_req for one cycle while ch0 is granted, then drops it -> no grant and no valid for ch1; p advances only on real grants.
